adder_cmp_ctrl: RTL

ADDER_CMP_CTRL -- requirements
Module: adder_cmp_ctrl

---
 rtl/adder_cmp_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adder_cmp_ctrl.sv
// adder_cmp_ctrl: registers an operand pair, waits for three external adders to
// settle, then captures the CLA sum, carry, signed overflow and cross-adder mismatch.
// Optional statistics counters are enabled with the macro ADDER_CMP_STATS_EN.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready, in_a/in_b   operand handshake
//   op_a, op_b                     registered operands to the adders
//   res_*/co_*                     adder sums and carries (cla, skip, sel)
//   out_valid/out_ready            result handshake
//   sum, cout, ovf, mismatch       captured result
//   stat_clr, op_count, err_count  statistics
module adder_cmp_ctrl #(
    parameter int WIDTH      = 32,
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] res_cla,
    input  logic [WIDTH-1:0] res_skip,
    input  logic [WIDTH-1:0] res_sel,
    input  logic             co_cla,
    input  logic             co_skip,
    input  logic             co_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [2:0]       mismatch,
    input  logic             stat_clr,
    output logic [15:0]      op_count,
    output logic [15:0]      err_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    // Counter holds SETTLE_CYC-1 at most.
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYC - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [2:0]       r_mismatch;

    logic             w_capture;
    logic             w_ovf;
    logic [2:0]       w_mismatch;
    logic [WIDTH:0]   w_cla;
    logic [WIDTH:0]   w_skip;
    logic [WIDTH:0]   w_sel;

    assign w_cla  = {co_cla, res_cla};
    assign w_skip = {co_skip, res_skip};
    assign w_sel  = {co_sel, res_sel};

    assign w_mismatch = {w_skip != w_sel, w_sel != w_cla, w_skip != w_cla};

    // Same operand signs, result sign differs.
    assign w_ovf = (r_op_a[WIDTH-1] == r_op_b[WIDTH-1])
                 && (res_cla[WIDTH-1] != r_op_a[WIDTH-1]);

    assign w_capture = (r_state == SETTLE) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_mismatch <= 3'b000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op_a  <= in_a;
                        r_op_b  <= in_b;
                        r_cnt   <= CNT_INIT;
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_capture) begin
                        r_sum      <= res_cla;
                        r_cout     <= co_cla;
                        r_ovf      <= w_ovf;
                        r_mismatch <= w_mismatch;
                        r_state    <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign mismatch  = r_mismatch;

`ifdef ADDER_CMP_STATS_EN
    logic [15:0] r_op_count;
    logic [15:0] r_err_count;
    logic        w_cap_err;

    assign w_cap_err = |w_mismatch;

    // Clear wins over a same-cycle increment; both counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count  <= '0;
            r_err_count <= '0;
        end else if (stat_clr) begin
            r_op_count  <= '0;
            r_err_count <= '0;
        end else if (w_capture) begin
            if (r_op_count != 16'hFFFF) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if (w_cap_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign op_count  = r_op_count;
    assign err_count = r_err_count;
`else
    logic w_stat_clr_unused;

    assign w_stat_clr_unused = stat_clr;
    assign op_count          = 16'd0;
    assign err_count         = 16'd0;
`endif

endmodule
